// File: rtl/ahbl_rr_arbiter.sv
// rtl/ahbl_rr_arbiter.sv - NM-master to 1-slave AHB-Lite round-robin arbiter and multiplexor
//
// Purpose:
//   Shares one AHB-Lite slave port between NM masters. Ownership changes only
//   at a re-arbitration point, so SEQ/BUSY bursts are never broken. The owner
//   of the address phase and the owner of the data phase are tracked separately.
//   Masters have no bus-request line: a master requests whenever HTRANS[1]=1,
//   and it is held off by driving its M_HREADY low.
//
// Ports:
//   HCLK, HRESETn                   clock, asynchronous active-low reset
//   M_HADDR/HTRANS/HBURST/HSIZE/
//   M_HWRITE/M_HWDATA/M_HMASTLOCK   per-master request side, master i in slice i
//   M_HREADY, M_HRESP               per-master ready/response
//   M_HRDATA                        read data, broadcast to every master
//   HADDR/HTRANS/HBURST/HSIZE/
//   HWRITE/HWDATA                   slave-side address and write data
//   HREADY, HRESP, HRDATA           slave-side ready, response, read data
//   HMASTLOCK                       forwarded lock (only with ARB_LOCK_EN)
//
// Optional feature macro: ARB_LOCK_EN
//   When defined, a granted master holding M_HMASTLOCK=1 blocks re-arbitration
//   (even while IDLE) and its lock is forwarded on HMASTLOCK. When undefined
//   M_HMASTLOCK is ignored and HMASTLOCK does not exist.

module ahbl_rr_arbiter #(
    parameter int NM = 3,
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [NM*AW-1:0] M_HADDR,
    input  logic [NM*2-1:0]  M_HTRANS,
    input  logic [NM*3-1:0]  M_HBURST,
    input  logic [NM*3-1:0]  M_HSIZE,
    input  logic [NM-1:0]    M_HWRITE,
    input  logic [NM*DW-1:0] M_HWDATA,
    input  logic [NM-1:0]    M_HMASTLOCK,
    output logic [NM-1:0]    M_HREADY,
    output logic [NM-1:0]    M_HRESP,
    output logic [DW-1:0]    M_HRDATA,
    output logic [AW-1:0]    HADDR,
    output logic [1:0]       HTRANS,
    output logic [2:0]       HBURST,
    output logic [2:0]       HSIZE,
    output logic             HWRITE,
`ifdef ARB_LOCK_EN
    output logic             HMASTLOCK,
`endif
    output logic [DW-1:0]    HWDATA,
    input  logic             HREADY,
    input  logic             HRESP,
    input  logic [DW-1:0]    HRDATA
);

    localparam int         PW          = (NM > 1) ? $clog2(NM) : 1;
    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    // gnt: address-phase owner, dwn: data-phase owner (both one-hot, 0 = none)
    // ptr: index of the most recently granted master
    logic [NM-1:0] gnt_q, gnt_d;
    logic [NM-1:0] dwn_q, dwn_d;
    logic [PW-1:0] ptr_q, ptr_d;

    logic [NM-1:0] req;
    logic [AW-1:0] haddr_m;
    logic [1:0]    htrans_m;
    logic [2:0]    hburst_m;
    logic [2:0]    hsize_m;
    logic          hwrite_m;
    logic          lock_m;
    logic [DW-1:0] hwdata_m;
    logic          arb_point;
    logic          rr_found;
    logic [NM-1:0] rr_gnt;
    logic [PW-1:0] rr_ptr;

    // A master requests whenever it drives NONSEQ or SEQ.
    always_comb begin
        req = '0;
        for (int i = 0; i < NM; i++) begin
            req[i] = M_HTRANS[2*i+1];
        end
    end

    // Address-phase mux. gnt is one-hot, so OR-ing the masked slices selects
    // the owner and yields all zeros (IDLE) when nobody owns the bus.
    always_comb begin
        haddr_m  = '0;
        htrans_m = '0;
        hburst_m = '0;
        hsize_m  = '0;
        hwrite_m = 1'b0;
        lock_m   = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (gnt_q[i]) begin
                haddr_m  = haddr_m  | M_HADDR[i*AW +: AW];
                htrans_m = htrans_m | M_HTRANS[i*2 +: 2];
                hburst_m = hburst_m | M_HBURST[i*3 +: 3];
                hsize_m  = hsize_m  | M_HSIZE[i*3 +: 3];
                hwrite_m = hwrite_m | M_HWRITE[i];
                lock_m   = lock_m   | M_HMASTLOCK[i];
            end
        end
    end

    // Data-phase mux follows the data owner, not the address owner.
    always_comb begin
        hwdata_m = '0;
        for (int i = 0; i < NM; i++) begin
            if (dwn_q[i]) begin
                hwdata_m = hwdata_m | M_HWDATA[i*DW +: DW];
            end
        end
    end

`ifdef ARB_LOCK_EN
    // A locked owner keeps the bus even through IDLE cycles.
    always_comb begin
        arb_point = HREADY && ((gnt_q == '0) || (htrans_m == HTRANS_IDLE)) && !lock_m;
    end
`else
    logic unused_lock;
    assign unused_lock = lock_m;

    // Only IDLE (never SEQ or BUSY) lets the bus change hands.
    always_comb begin
        arb_point = HREADY && ((gnt_q == '0) || (htrans_m == HTRANS_IDLE));
    end
`endif

    // Round-robin search starting at ptr+1. The outer loop walks priority
    // order; the inner loop matches the wrapped index to a constant master
    // index so every bit select stays static.
    always_comb begin
        rr_found = 1'b0;
        rr_gnt   = '0;
        rr_ptr   = ptr_q;
        for (int k = 1; k <= NM; k++) begin
            for (int i = 0; i < NM; i++) begin
                if (!rr_found && req[i] && (((int'(ptr_q) + k) % NM) == i)) begin
                    rr_found  = 1'b1;
                    rr_gnt[i] = 1'b1;
                    rr_ptr    = PW'(i);
                end
            end
        end
    end

    // Next state. At an arbitration point the owner is IDLE, so dwn naturally
    // falls to 0 on the same edge that gnt moves.
    always_comb begin
        gnt_d = gnt_q;
        ptr_d = ptr_q;
        dwn_d = dwn_q;
        if (HREADY) begin
            dwn_d = htrans_m[1] ? gnt_q : '0;
        end
        if (arb_point && rr_found) begin
            gnt_d = rr_gnt;
            ptr_d = rr_ptr;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            gnt_q <= '0;
            dwn_q <= '0;
            ptr_q <= PW'(NM - 1);
        end else begin
            gnt_q <= gnt_d;
            dwn_q <= dwn_d;
            ptr_q <= ptr_d;
        end
    end

    // Non-owners that request are stalled holding their address; idle
    // non-owners see ready so they are free to start a transfer.
    always_comb begin
        M_HREADY = '0;
        M_HRESP  = '0;
        for (int i = 0; i < NM; i++) begin
            M_HREADY[i] = gnt_q[i] ? HREADY : ~req[i];
            M_HRESP[i]  = dwn_q[i] & HRESP;
        end
    end

    assign M_HRDATA = HRDATA;
    assign HADDR    = haddr_m;
    assign HTRANS   = htrans_m;
    assign HBURST   = hburst_m;
    assign HSIZE    = hsize_m;
    assign HWRITE   = hwrite_m;
    assign HWDATA   = hwdata_m;
`ifdef ARB_LOCK_EN
    assign HMASTLOCK = lock_m;
`endif

endmodule

// File: tb/tb_ahbl_rr_arbiter.sv
// tb/tb_ahbl_rr_arbiter.sv - self-checking bench for ahbl_rr_arbiter
module tb_ahbl_rr_arbiter;
    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MANUAL = 0;
    localparam int LOOP = 1;
    localparam int RAND = 2;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b1;
    always #5 HCLK = ~HCLK;

    logic [1:0]    tr [NM];
    logic [AW-1:0] ad [NM];
    logic [2:0]    bu [NM];
    logic [2:0]    sz [NM];
    logic          wr [NM];
    logic [DW-1:0] wd [NM];
    logic          lk [NM];
    int            mode [NM];

    logic [NM*AW-1:0] m_haddr;
    logic [NM*2-1:0]  m_htrans;
    logic [NM*3-1:0]  m_hburst;
    logic [NM*3-1:0]  m_hsize;
    logic [NM-1:0]    m_hwrite;
    logic [NM*DW-1:0] m_hwdata;
    logic [NM-1:0]    m_hmastlock;
    logic [NM-1:0]    m_hready;
    logic [NM-1:0]    m_hresp;
    logic [DW-1:0]    m_hrdata;
    logic [AW-1:0]    haddr;
    logic [1:0]       htrans;
    logic [2:0]       hburst;
    logic [2:0]       hsize;
    logic             hwrite;
    logic [DW-1:0]    hwdata;
    logic             hready;
    logic             hresp;
    logic [DW-1:0]    hrdata;
`ifdef ARB_LOCK_EN
    logic             hmastlock;
`endif

    for (genvar g = 0; g < NM; g++) begin : g_pack
        assign m_haddr[g*AW +: AW]  = ad[g];
        assign m_htrans[g*2 +: 2]   = tr[g];
        assign m_hburst[g*3 +: 3]   = bu[g];
        assign m_hsize[g*3 +: 3]    = sz[g];
        assign m_hwrite[g]          = wr[g];
        assign m_hwdata[g*DW +: DW] = wd[g];
        assign m_hmastlock[g]       = lk[g];
    end

    ahbl_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M_HADDR(m_haddr), .M_HTRANS(m_htrans), .M_HBURST(m_hburst),
        .M_HSIZE(m_hsize), .M_HWRITE(m_hwrite), .M_HWDATA(m_hwdata),
        .M_HMASTLOCK(m_hmastlock), .M_HREADY(m_hready), .M_HRESP(m_hresp),
        .M_HRDATA(m_hrdata), .HADDR(haddr), .HTRANS(htrans), .HBURST(hburst),
        .HSIZE(hsize), .HWRITE(hwrite),
`ifdef ARB_LOCK_EN
        .HMASTLOCK(hmastlock),
`endif
        .HWDATA(hwdata), .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata)
    );

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: owner index (-1 = none), data owner, last granted index.
    int mg = -1;
    int md = -1;
    int mp = NM - 1;

    function automatic logic [1:0] owner_tr(input int g);
        return (g >= 0) ? tr[g] : 2'b00;
    endfunction

    function automatic bit model_arb(input int g);
        bit ok;
        ok = hready && (owner_tr(g) == 2'b00);
`ifdef ARB_LOCK_EN
        if (g >= 0 && lk[g]) ok = 1'b0;
`endif
        return ok;
    endfunction

    function automatic int rr_pick(input int p);
        for (int k = 1; k <= NM; k++) begin
            int idx;
            idx = (p + k) % NM;
            if (tr[idx][1]) return idx;
        end
        return -1;
    endfunction

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            mg <= -1;
            md <= -1;
            mp <= NM - 1;
        end else begin
            if (hready) md <= owner_tr(mg)[1] ? mg : -1;
            if (model_arb(mg) && rr_pick(mp) >= 0) begin
                mg <= rr_pick(mp);
                mp <= rr_pick(mp);
            end
        end
    end

    task automatic check_model();
        logic [NM-1:0] e_rdy;
        logic [NM-1:0] e_resp;
        e_rdy = '0;
        e_resp = '0;
        for (int i = 0; i < NM; i++) begin
            e_rdy[i]  = (mg == i) ? hready : ~tr[i][1];
            e_resp[i] = (md == i) ? hresp : 1'b0;
        end
        chk("model_htrans", htrans, owner_tr(mg));
        chk("model_haddr", haddr, (mg >= 0) ? ad[mg] : '0);
        chk("model_hburst", hburst, (mg >= 0) ? bu[mg] : '0);
        chk("model_hsize", hsize, (mg >= 0) ? sz[mg] : '0);
        chk("model_hwrite", hwrite, (mg >= 0) ? wr[mg] : 1'b0);
        chk("model_hwdata", hwdata, (md >= 0) ? wd[md] : '0);
        chk("model_m_hready", m_hready, e_rdy);
        chk("model_m_hresp", m_hresp, e_resp);
        chk("model_m_hrdata", m_hrdata, hrdata);
`ifdef ARB_LOCK_EN
        chk("model_hmastlock", hmastlock, (mg >= 0) ? lk[mg] : 1'b0);
`endif
    endtask

    always @(negedge HCLK) check_model();

    logic [NM-1:0] rdy_s;

    task automatic mid();
        @(negedge HCLK);
        #1;
        rdy_s = m_hready;
    endtask

    task automatic adv_masters();
        int r;
        for (int i = 0; i < NM; i++) begin
            if (mode[i] == LOOP) begin
                if (tr[i] == 2'b10 && rdy_s[i]) begin
                    tr[i] = 2'b00;
                    ad[i] = ad[i] + 32'd4;
                end else if (tr[i] == 2'b00) begin
                    tr[i] = 2'b10;
                end
            end else if (mode[i] == RAND) begin
                if (!(tr[i][1] && !rdy_s[i])) begin
                    r = $urandom_range(0, 9);
                    tr[i] = (r < 4) ? 2'b00 : (r < 7) ? 2'b10 : (r < 9) ? 2'b11 : 2'b01;
                    ad[i] = $urandom;
                    bu[i] = 3'($urandom_range(0, 7));
                    sz[i] = 3'($urandom_range(0, 3));
                    wr[i] = 1'($urandom_range(0, 1));
                    wd[i] = {$urandom, $urandom};
                    lk[i] = ($urandom_range(0, 3) == 0);
                end
            end
        end
    endtask

    task automatic edge_();
        @(posedge HCLK);
        #1;
        adv_masters();
    endtask

    task automatic idle_all();
        for (int i = 0; i < NM; i++) begin
            mode[i] = MANUAL;
            tr[i] = 2'b00; ad[i] = '0; bu[i] = '0; sz[i] = '0;
            wr[i] = 1'b0; wd[i] = '0; lk[i] = 1'b0;
        end
        hready = 1'b1;
        hresp = 1'b0;
        hrdata = '0;
    endtask

    task automatic do_reset();
        idle_all();
        #2 HRESETn = 1'b0;
        edge_();
        edge_();
        HRESETn = 1'b1;
    endtask

    logic [31:0] t3_addr [4];

    initial begin
        idle_all();
        rdy_s = '0;
        t3_addr[0] = 32'h100; t3_addr[1] = 32'h200; t3_addr[2] = 32'h300; t3_addr[3] = 32'h104;

        // Reset with every master IDLE
        #2 HRESETn = 1'b0;
        mid();
        chk("t1_htrans", htrans, 2'b00);
        chk("t1_haddr", haddr, 32'h0);
        chk("t1_hwdata", hwdata, 64'h0);
        chk("t1_m_hready", m_hready, 3'b111);
        chk("t1_m_hresp", m_hresp, 3'b000);
        edge_();
        edge_();
        HRESETn = 1'b1;
        mid();
        chk("t1_post_htrans", htrans, 2'b00);
        chk("t1_post_m_hready", m_hready, 3'b111);
        edge_();

        // Single read from M0 after reset
        do_reset();
        tr[0] = 2'b10; ad[0] = 32'h1000; hrdata = 64'hDEAD_BEEF;
        mid();
        chk("t2_c0_m_hready0", m_hready[0], 1'b0);
        chk("t2_c0_htrans", htrans, 2'b00);
        edge_();
        mid();
        chk("t2_c1_htrans", htrans, 2'b10);
        chk("t2_c1_haddr", haddr, 32'h1000);
        chk("t2_model_owner", 64'(mg), 64'd0);
        edge_();
        tr[0] = 2'b00;
        mid();
        chk("t2_c2_m_hrdata", m_hrdata, 64'hDEAD_BEEF);
        chk("t2_c2_m_hready0", m_hready[0], 1'b1);
        edge_();

        // Three looping masters: grant order 0,1,2,0 with one bubble per switch
        do_reset();
        for (int i = 0; i < NM; i++) begin
            mode[i] = LOOP;
            tr[i] = 2'b10;
            ad[i] = 32'h100 * (i + 1);
        end
        for (int c = 0; c < 8; c++) begin
            mid();
            if (c % 2 == 0) begin
                chk("t3_bubble_htrans", htrans, 2'b00);
            end else begin
                chk("t3_htrans", htrans, 2'b10);
                chk("t3_grant_addr", haddr, t3_addr[c/2]);
            end
            edge_();
        end

        // INCR4 write from M1 while M0 requests
        do_reset();
        tr[1] = 2'b10; ad[1] = 32'h2000; bu[1] = 3'b011; sz[1] = 3'b010; wr[1] = 1'b1;
        mid();
        edge_();
        tr[0] = 2'b10; ad[0] = 32'h1000;
        mid();
        chk("t4_b0_haddr", haddr, 32'h2000);
        chk("t4_b0_htrans", htrans, 2'b10);
        chk("t4_b0_m_hready0", m_hready[0], 1'b0);
        for (int b = 1; b < 4; b++) begin
            edge_();
            tr[1] = 2'b11; ad[1] = 32'h2000 + 32'(4 * b); wd[1] = 64'hA0 + 64'(b - 1);
            mid();
            chk("t4_beat_haddr", haddr, 32'h2000 + 32'(4 * b));
            chk("t4_beat_htrans", htrans, 2'b11);
            chk("t4_beat_m_hready0", m_hready[0], 1'b0);
            chk("t4_beat_hwdata", hwdata, 64'hA0 + 64'(b - 1));
        end
        edge_();
        tr[1] = 2'b00; wd[1] = 64'hA3;
        mid();
        chk("t4_idle_htrans", htrans, 2'b00);
        chk("t4_idle_m_hready0", m_hready[0], 1'b0);
        chk("t4_last_hwdata", hwdata, 64'hA3);
        edge_();
        mid();
        chk("t4_m0_htrans", htrans, 2'b10);
        chk("t4_m0_haddr", haddr, 32'h1000);
        chk("t4_m0_hwdata", hwdata, 64'h0);
        #2 HRESETn = 1'b0;
        #1;
        chk("t4_async_rst_htrans", htrans, 2'b00);
        chk("t4_async_rst_haddr", haddr, 32'h0);

        // Wait states and two-cycle ERROR in M1's write data phase
        do_reset();
        tr[1] = 2'b10; ad[1] = 32'h3000; wr[1] = 1'b1;
        tr[2] = 2'b10; ad[2] = 32'h4000;
        mid();
        edge_();
        mid();
        chk("t5_m1_haddr", haddr, 32'h3000);
        edge_();
        tr[1] = 2'b00; wd[1] = 64'h1122334455667788; hready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mid();
            chk("t5_wait_hwdata", hwdata, 64'h1122334455667788);
            chk("t5_wait_m_hready1", m_hready[1], 1'b0);
            chk("t5_wait_m_hready2", m_hready[2], 1'b0);
            chk("t5_wait_htrans", htrans, 2'b00);
            chk("t5_wait_m_hresp", m_hresp, (c == 2) ? 3'b010 : 3'b000);
            edge_();
            if (c == 1) hresp = 1'b1;
            if (c == 2) hready = 1'b1;
        end
        mid();
        chk("t5_err2_m_hresp", m_hresp, 3'b010);
        chk("t5_err2_m_hready1", m_hready[1], 1'b1);
        chk("t5_err2_m_hready2", m_hready[2], 1'b0);
        edge_();
        hresp = 1'b0;
        mid();
        chk("t5_m2_htrans", htrans, 2'b10);
        chk("t5_m2_haddr", haddr, 32'h4000);
        chk("t5_m2_hwdata", hwdata, 64'h0);
        edge_();

`ifdef ARB_LOCK_EN
        // Locked M2 keeps the bus across an IDLE
        do_reset();
        tr[2] = 2'b10; ad[2] = 32'h5000; lk[2] = 1'b1;
        mid();
        edge_();
        tr[0] = 2'b10; ad[0] = 32'h1000;
        mid();
        chk("t6_haddr", haddr, 32'h5000);
        chk("t6_hmastlock", hmastlock, 1'b1);
        edge_();
        tr[2] = 2'b00;
        mid();
        chk("t6_locked_idle_m_hready0", m_hready[0], 1'b0);
        edge_();
        tr[2] = 2'b10; ad[2] = 32'h5010;
        mid();
        chk("t6_second_haddr", haddr, 32'h5010);
        edge_();
        tr[2] = 2'b00; lk[2] = 1'b0;
        mid();
        chk("t6_unlock_htrans", htrans, 2'b00);
        edge_();
        mid();
        chk("t6_m0_haddr", haddr, 32'h1000);
        chk("t6_m0_hmastlock", hmastlock, 1'b0);
        edge_();
`endif

        // Randomized traffic with an asynchronous reset pulse mid-run
        do_reset();
        for (int i = 0; i < NM; i++) mode[i] = RAND;
        for (int c = 0; c < 4000; c++) begin
            mid();
            edge_();
            hready = ($urandom_range(0, 9) < 7);
            hresp = ($urandom_range(0, 7) == 0);
            hrdata = {$urandom, $urandom};
            if (c == 2000) #2 HRESETn = 1'b0;
            if (c == 2003) HRESETn = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
